// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that shares one N-bit adder among REQS requesters.
// One requester is granted at a time; its sum is returned with its ID over a valid/ready port.
module adder_share_arbiter #(
    parameter int N    = 10,
    parameter int REQS = 4,
    localparam int IDW = $clog2(REQS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REQS-1:0]   req,
    input  logic [REQS*N-1:0] a_in,
    input  logic [REQS*N-1:0] b_in,
    output logic [REQS-1:0]   ack,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N:0]        res_sum,
    output logic [IDW-1:0]    res_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [REQS-1:0] ACK_ONE = {{(REQS-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]    op_a_q, op_a_d;
    logic [N-1:0]    op_b_q, op_b_d;
    logic [REQS-1:0] ack_q, ack_d;
    logic            res_valid_q, res_valid_d;
    logic [N:0]      res_sum_q, res_sum_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic            busy_q, busy_d;

    logic [IDW-1:0]  gnt_s;
    logic            gnt_found_s;
    logic [N-1:0]    a_sel_s;
    logic [N-1:0]    b_sel_s;
    logic [N:0]      sum_s;

    // Round-robin search: first set request bit at ptr, ptr+1, ... wrapping modulo REQS.
    always_comb begin
        logic [IDW:0] idx_v;
        gnt_s       = '0;
        gnt_found_s = 1'b0;
        idx_v       = '0;
        for (int off = 0; off < REQS; off++) begin
            idx_v = {1'b0, ptr_q} + (IDW+1)'(off);
            if (idx_v >= (IDW+1)'(REQS)) begin
                idx_v = idx_v - (IDW+1)'(REQS);
            end else begin
                idx_v = idx_v;
            end
            if (!gnt_found_s && req[idx_v[IDW-1:0]]) begin
                gnt_found_s = 1'b1;
                gnt_s       = idx_v[IDW-1:0];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Operand mux selecting the granted requester's slices.
    always_comb begin
        a_sel_s = '0;
        b_sel_s = '0;
        for (int i = 0; i < REQS; i++) begin
            if (gnt_s == IDW'(i)) begin
                a_sel_s = a_in[i*N +: N];
                b_sel_s = b_in[i*N +: N];
            end else begin
                a_sel_s = a_sel_s;
                b_sel_s = b_sel_s;
            end
        end
    end

    // The single shared adder, zero-extended so the carry lands in bit N.
    always_comb begin
        sum_s = {1'b0, op_a_q} + {1'b0, op_b_q};
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        ack_d       = '0;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found_s) begin
                    op_a_d   = a_sel_s;
                    op_b_d   = b_sel_s;
                    ack_d    = ACK_ONE << gnt_s;
                    res_id_d = gnt_s;
                    if (gnt_s == IDW'(REQS-1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gnt_s + IDW'(1);
                    end
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                res_sum_d   = sum_s;
                res_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            ack_q       <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
            busy_q      <= busy_d;
        end
    end

    assign ack       = ack_q;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: stimulus pushes expected acks/results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_adder_share_arbiter;

    localparam int N    = 10;
    localparam int REQS = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REQS-1:0]   req;
    logic [REQS*N-1:0] a_in;
    logic [REQS*N-1:0] b_in;
    logic [REQS-1:0]   ack;
    logic              res_valid;
    logic              res_ready;
    logic [N:0]        res_sum;
    logic [IDW-1:0]    res_id;
    logic              busy;

    adder_share_arbiter #(.N(N), .REQS(REQS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .ack       (ack),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [REQS-1:0] ack;
        int              gap;
    } ack_exp_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [N:0]     sum;
    } res_exp_t;

    ack_exp_t ack_exp_q[$];
    res_exp_t res_exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic exp_ack(input logic [REQS-1:0] m, input int gap);
        ack_exp_t e;
        e.ack = m;
        e.gap = gap;
        ack_exp_q.push_back(e);
    endtask

    task automatic exp_res(input logic [IDW-1:0] id, input logic [N:0] sum);
        res_exp_t e;
        e.id  = id;
        e.sum = sum;
        res_exp_q.push_back(e);
    endtask

    task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        a_in[i*N +: N] = a;
        b_in[i*N +: N] = b;
    endtask

    task automatic wait_ack(input logic [REQS-1:0] mask);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            if ((ack & mask) != '0) seen = 1'b1;
        end
        check("ack_arrives", 32'(seen), 32'd1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 40 && !idle; k++) begin
            @(posedge clk); #1;
            if (!busy && !res_valid) idle = 1'b1;
        end
        check("drain_to_idle", 32'(idle), 32'd1);
    endtask

    // Monitor: compares every ack pulse and every accepted result against the queues.
    ack_exp_t ae;
    res_exp_t re;
    int last_ack_cyc = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (ack != '0) begin
                    if (ack_exp_q.size() == 0) begin
                        check("unexpected_ack", 32'(ack), 32'd0);
                    end else begin
                        ae = ack_exp_q.pop_front();
                        check("ack_onehot", 32'(ack), 32'(ae.ack));
                        if (ae.gap != 0) check("grant_spacing", cyc - last_ack_cyc, ae.gap);
                    end
                    last_ack_cyc = cyc;
                end
                if (res_valid && res_ready) begin
                    if (res_exp_q.size() == 0) begin
                        check("unexpected_result", 32'(res_exp_q.size()), 32'd1);
                    end else begin
                        re = res_exp_q.pop_front();
                        check("res_id", 32'(res_id), 32'(re.id));
                        check("res_sum", 32'(res_sum), 32'(re.sum));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        res_ready = 1'b1;
        #3;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_sum", 32'(res_sum), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full contention from ptr=0: order 0,1,2,3,0, three cycles apart.
        for (int i = 0; i < REQS; i++) set_ops(i, N'(100 * i), N'(1));
        exp_ack(4'b0001, 0); exp_res(2'd0, 11'd1);
        exp_ack(4'b0010, 3); exp_res(2'd1, 11'd101);
        exp_ack(4'b0100, 3); exp_res(2'd2, 11'd201);
        exp_ack(4'b1000, 3); exp_res(2'd3, 11'd301);
        exp_ack(4'b0001, 3); exp_res(2'd0, 11'd1);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) wait_ack(4'b1111);
        req = 4'b0000;
        wait_idle();

        // Single request: 12+28, two-edge latency, busy for two cycles.
        set_ops(0, 10'd12, 10'd28);
        exp_ack(4'b0001, 0); exp_res(2'd0, 11'd40);
        req = 4'b0001;
        wait_ack(4'b0001);
        req = 4'b0000;
        check("single_busy_on_grant", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("single_valid_latency", 32'(res_valid), 32'd1);
        check("single_busy_second", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("single_busy_fall", 32'(busy), 32'd0);
        check("single_valid_fall", 32'(res_valid), 32'd0);
        check("single_sum_kept", 32'(res_sum), 32'd40);

        // Width boundary: carry into bit N, then all-zero operands.
        set_ops(1, 10'd1023, 10'd1023);
        exp_ack(4'b0010, 0); exp_res(2'd1, 11'd2046);
        req = 4'b0010;
        wait_ack(4'b0010);
        req = 4'b0000;
        wait_idle();
        set_ops(1, 10'd0, 10'd0);
        exp_ack(4'b0010, 0); exp_res(2'd1, 11'd0);
        req = 4'b0010;
        wait_ack(4'b0010);
        req = 4'b0000;
        wait_idle();

        // Pointer wrap: grant 3, then 1001 goes to 0, then 1001 goes to 3.
        set_ops(3, 10'd5, 10'd6);
        set_ops(0, 10'd7, 10'd8);
        exp_ack(4'b1000, 0); exp_res(2'd3, 11'd11);
        req = 4'b1000;
        wait_ack(4'b1000);
        req = 4'b0000;
        wait_idle();
        exp_ack(4'b0001, 0); exp_res(2'd0, 11'd15);
        req = 4'b1001;
        wait_ack(4'b1001);
        req = 4'b0000;
        wait_idle();
        exp_ack(4'b1000, 0); exp_res(2'd3, 11'd11);
        req = 4'b1001;
        wait_ack(4'b1001);
        req = 4'b0000;
        wait_idle();

        // Backpressure: result held for 5 cycles while requester 2 waits.
        res_ready = 1'b0;
        set_ops(0, 10'd120, 10'd68);
        set_ops(2, 10'd3, 10'd4);
        exp_ack(4'b0001, 0); exp_res(2'd0, 11'd188);
        req = 4'b0001;
        wait_ack(4'b0001);
        exp_ack(4'b0100, 0); exp_res(2'd2, 11'd7);
        req = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_valid_held", 32'(res_valid), 32'd1);
            check("bp_sum_held", 32'(res_sum), 32'd188);
            check("bp_id_held", 32'(res_id), 32'd0);
            check("bp_no_ack", 32'(ack), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_accept_valid", 32'(res_valid), 32'd0);
        check("bp_accept_no_ack", 32'(ack), 32'd0);
        @(posedge clk); #1;
        check("bp_next_grant", 32'(ack), 32'b0100);
        req = 4'b0000;
        wait_idle();

        // Asynchronous reset during CALC discards the transaction and clears ptr.
        set_ops(1, 10'd1, 10'd1);
        req = 4'b0010;
        wait_ack(4'b0010);
        req = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sum", 32'(res_sum), 32'd0);
        check("mid_rst_id", 32'(res_id), 32'd0);
        set_ops(1, 10'd10, 10'd20);
        set_ops(2, 10'd50, 10'd60);
        exp_ack(4'b0010, 0); exp_res(2'd1, 11'd30);
        req = 4'b0110;
        @(posedge clk); #1 rst_n = 1'b1;
        wait_ack(4'b0110);
        req = 4'b0000;
        wait_idle();

        check("ack_queue_drained", 32'(ack_exp_q.size()), 32'd0);
        check("res_queue_drained", 32'(res_exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
